// File: rtl/operand_fetch.sv
// Decode/operand-read stage: holds one instruction, reads the regfile, applies
// EX/MEM/WB bypass and hands a resolved payload to EX over a valid/ready register.
module operand_fetch #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_pc,
    input  logic [31:0]      in_instr,

    output logic [4:0]       rf_raddr1,
    output logic [4:0]       rf_raddr2,
    input  logic [XLEN-1:0]  rf_rdata1,
    input  logic [XLEN-1:0]  rf_rdata2,

    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic [XLEN-1:0]  ex_result,

    input  logic             mem_valid,
    input  logic             mem_data_ok,
    input  logic [4:0]       mem_rd,
    input  logic [XLEN-1:0]  mem_result,

    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_data,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_pc,
    output logic [31:0]      out_instr,
    output logic [XLEN-1:0]  out_rs1_val,
    output logic [XLEN-1:0]  out_rs2_val,
    output logic [4:0]       out_rd,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpReg32  = 7'b0111011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic            idValid;
    logic [63:0]     idPc;
    logic [31:0]     idInstr;

    logic [6:0]      opcode;
    logic [4:0]      rsAddr [2];
    logic [XLEN-1:0] rfData [2];
    logic [XLEN-1:0] opVal  [2];
    logic [1:0]      opUsed;
    logic [1:0]      opHaz;
    logic [1:0]      exHit;
    logic [1:0]      memHit;
    logic [1:0]      wbHit;

    logic            hazard;
    logic            xfer;

    assign opcode    = idInstr[6:0];
    assign rsAddr[0] = idInstr[19:15];
    assign rsAddr[1] = idInstr[24:20];
    assign rfData[0] = rf_rdata1;
    assign rfData[1] = rf_rdata2;
    assign rf_raddr1 = rsAddr[0];
    assign rf_raddr2 = rsAddr[1];

    always_comb begin
        opUsed    = 2'b00;
        opUsed[0] = !(opcode == OpLui || opcode == OpAuipc || opcode == OpJal);
        opUsed[1] = (opcode == OpReg) || (opcode == OpReg32) ||
                    (opcode == OpStore) || (opcode == OpBranch);
    end

    // Bypass priority EX > MEM > WB > regfile. WB must be forwarded because the
    // regfile write lands on the same edge this stage samples its operands.
    always_comb begin
        exHit  = 2'b00;
        memHit = 2'b00;
        wbHit  = 2'b00;
        opHaz  = 2'b00;
        for (int i = 0; i < 2; i++) begin
            opVal[i]  = '0;
            exHit[i]  = ex_valid  && (ex_rd  == rsAddr[i]) && (ex_rd  != 5'd0);
            memHit[i] = mem_valid && (mem_rd == rsAddr[i]) && (mem_rd != 5'd0);
            wbHit[i]  = wb_valid  && (wb_rd  == rsAddr[i]) && (wb_rd  != 5'd0);
            opHaz[i]  = opUsed[i] && ((exHit[i] && ex_is_load) ||
                                      (!exHit[i] && memHit[i] && !mem_data_ok));
            if (rsAddr[i] == 5'd0) begin
                opVal[i] = '0;
            end else if (exHit[i]) begin
                opVal[i] = ex_result;
            end else if (memHit[i]) begin
                opVal[i] = mem_result;
            end else if (wbHit[i]) begin
                opVal[i] = wb_data;
            end else begin
                opVal[i] = rfData[i];
            end
        end
    end

    assign hazard   = |opHaz;
    assign xfer     = idValid && !hazard && (!out_valid || out_ready);
    // Held low in reset and on flush so fetch never sees a handshake that gets dropped.
    assign in_ready = rst_n && !flush && (!idValid || xfer);
    assign out_rd   = out_instr[11:7];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idValid     <= 1'b0;
            idPc        <= '0;
            idInstr     <= '0;
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_instr   <= '0;
            out_rs1_val <= '0;
            out_rs2_val <= '0;
        end else if (flush) begin
            idValid   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                idValid <= 1'b1;
                idPc    <= in_pc;
                idInstr <= in_instr;
            end else if (xfer) begin
                idValid <= 1'b0;
            end

            if (xfer) begin
                out_valid   <= 1'b1;
                out_pc      <= idPc;
                out_instr   <= idInstr;
                out_rs1_val <= opVal[0];
                out_rs2_val <= opVal[1];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (idValid && hazard && !flush && (stall_cnt != CntMax)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: reset, bypass paths, load-use stall,
// backpressure, flush and stall counter saturation (counter narrowed to 3 bits).
module tb_operand_fetch;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned CNT_W = 3;

    localparam logic [31:0] IAddi1   = 32'h0050_0093; // addi x1,x0,5
    localparam logic [31:0] IAdd2    = 32'h0010_8133; // add  x2,x1,x1
    localparam logic [31:0] IAdd4x3  = 32'h0001_8233; // add  x4,x3,x0
    localparam logic [31:0] IAdd4x33 = 32'h0031_8233; // add  x4,x3,x3
    localparam logic [31:0] IAdd5x7  = 32'h0003_82B3; // add  x5,x7,x0
    localparam logic [31:0] IAdd6x0  = 32'h0000_0333; // add  x6,x0,x0

    logic             clk = 1'b0;
    logic             rst_n, flush, in_valid, in_ready;
    logic [63:0]      in_pc;
    logic [31:0]      in_instr;
    logic [4:0]       rf_raddr1, rf_raddr2;
    logic [XLEN-1:0]  rf_rdata1, rf_rdata2;
    logic             ex_valid, ex_is_load;
    logic [4:0]       ex_rd;
    logic [XLEN-1:0]  ex_result;
    logic             mem_valid, mem_data_ok;
    logic [4:0]       mem_rd;
    logic [XLEN-1:0]  mem_result;
    logic             wb_valid;
    logic [4:0]       wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic             out_valid, out_ready;
    logic [63:0]      out_pc;
    logic [31:0]      out_instr;
    logic [XLEN-1:0]  out_rs1_val, out_rs2_val;
    logic [4:0]       out_rd;
    logic [CNT_W-1:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    operand_fetch #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_instr    (in_instr),
        .rf_raddr1   (rf_raddr1),
        .rf_raddr2   (rf_raddr2),
        .rf_rdata1   (rf_rdata1),
        .rf_rdata2   (rf_rdata2),
        .ex_valid    (ex_valid),
        .ex_is_load  (ex_is_load),
        .ex_rd       (ex_rd),
        .ex_result   (ex_result),
        .mem_valid   (mem_valid),
        .mem_data_ok (mem_data_ok),
        .mem_rd      (mem_rd),
        .mem_result  (mem_result),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .out_rs1_val (out_rs1_val),
        .out_rs2_val (out_rs2_val),
        .out_rd      (out_rd),
        .stall_cnt   (stall_cnt)
    );

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [63:0] pc, input logic [31:0] instr);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr;
    endtask

    task automatic clearFwd();
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0; ex_result = '0;
        mem_valid = 1'b0; mem_data_ok = 1'b1; mem_rd = 5'd0; mem_result = '0;
        wb_valid = 1'b0; wb_rd = 5'd0; wb_data = '0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        rf_rdata1 = '0; rf_rdata2 = '0;
        clearFwd();
        offer(64'h100, IAddi1);

        // Reset held 2 cycles with an offered instruction.
        #1;
        checkEq("rst_in_ready_pre", in_ready, 0);
        for (int i = 0; i < 2; i++) begin
            step();
            checkEq("rst_out_valid", out_valid, 0);
            checkEq("rst_stall_cnt", stall_cnt, 0);
            checkEq("rst_in_ready", in_ready, 0);
            checkEq("rst_out_pc", out_pc, 0);
        end
        rst_n = 1'b1;
        #1;
        checkEq("rel_in_ready", in_ready, 1);

        // ADDI x1 then ADD x2,x1,x1 with EX forwarding of 5.
        step();                                   // ADDI captured
        checkEq("addi_not_out_yet", out_valid, 0);
        offer(64'h104, IAdd2);
        rf_rdata1 = 64'h99; rf_rdata2 = 64'h99;
        step();                                   // ADDI -> out, ADD captured
        checkEq("addi_out_valid", out_valid, 1);
        checkEq("addi_out_pc", out_pc, 64'h100);
        checkEq("addi_x0_val", out_rs1_val, 0);
        checkEq("addi_out_rd", out_rd, 1);
        in_valid = 1'b0;
        ex_valid = 1'b1; ex_rd = 5'd1; ex_result = 64'd5;
        rf_rdata1 = 64'hBAD; rf_rdata2 = 64'hBAD;
        #1;
        checkEq("add_raddr1", rf_raddr1, 1);
        checkEq("add_raddr2", rf_raddr2, 1);
        checkEq("add_in_ready", in_ready, 1);
        step();
        checkEq("add_out_pc", out_pc, 64'h104);
        checkEq("add_rs1_ex", out_rs1_val, 5);
        checkEq("add_rs2_ex", out_rs2_val, 5);
        checkEq("add_out_rd", out_rd, 2);
        checkEq("add_no_stall", stall_cnt, 0);

        // Load-use: one stall cycle, then MEM forwarding.
        clearFwd();
        offer(64'h108, IAdd4x3);
        step();
        in_valid = 1'b0;
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd3; ex_result = 64'h5555;
        #1;
        checkEq("lu_in_ready", in_ready, 0);
        step();
        checkEq("lu_stall_cnt", stall_cnt, 1);
        checkEq("lu_out_drained", out_valid, 0);
        clearFwd();
        mem_valid = 1'b1; mem_data_ok = 1'b1; mem_rd = 5'd3; mem_result = 64'hDEAD;
        step();
        checkEq("lu_out_valid", out_valid, 1);
        checkEq("lu_rs1_mem", out_rs1_val, 64'hDEAD);
        checkEq("lu_rs2_x0", out_rs2_val, 0);
        checkEq("lu_stall_hold", stall_cnt, 1);

        // MEM result not ready stalls; EX beats MEM when both match.
        clearFwd();
        offer(64'h10C, IAdd4x33);
        step();
        in_valid = 1'b0;
        mem_valid = 1'b1; mem_data_ok = 1'b0; mem_rd = 5'd3; mem_result = 64'hAAA;
        step();
        checkEq("memwait_stall_cnt", stall_cnt, 2);
        checkEq("memwait_no_out", out_valid, 0);
        ex_valid = 1'b1; ex_rd = 5'd3; ex_result = 64'hE;
        step();
        checkEq("prio_rs1_ex", out_rs1_val, 64'hE);
        checkEq("prio_rs2_ex", out_rs2_val, 64'hE);
        checkEq("prio_stall_cnt", stall_cnt, 2);

        // WB bypass over a stale regfile; x0 with wb_rd=0 stays 0.
        clearFwd();
        offer(64'h110, IAdd5x7);
        step();
        offer(64'h114, IAdd6x0);
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 64'h1234; rf_rdata1 = 64'h0;
        #1;
        checkEq("wb_raddr1", rf_raddr1, 7);
        step();
        checkEq("wb_rs1_val", out_rs1_val, 64'h1234);
        checkEq("wb_out_pc", out_pc, 64'h110);
        in_valid = 1'b0;
        wb_rd = 5'd0; wb_data = 64'h5555; rf_rdata1 = 64'h77;
        step();
        checkEq("wb_x0_val", out_rs1_val, 0);
        checkEq("wb_x0_pc", out_pc, 64'h114);
        clearFwd();
        step();
        checkEq("drain_out_valid", out_valid, 0);

        // Backpressure: out_ready low 3 cycles with instructions offered.
        out_ready = 1'b0;
        offer(64'h200, IAdd6x0);
        step();                                   // A in ID
        offer(64'h204, IAdd6x0);
        step();                                   // A out, B in ID
        offer(64'h208, IAdd6x0);
        for (int i = 0; i < 3; i++) begin
            checkEq("bp_out_valid", out_valid, 1);
            checkEq("bp_out_pc", out_pc, 64'h200);
            checkEq("bp_in_ready", in_ready, 0);
            step();
        end
        checkEq("bp_out_pc_last", out_pc, 64'h200);
        out_ready = 1'b1;
        #1;
        checkEq("bp_release_ready", in_ready, 1);
        step();                                   // B out, C in ID
        in_valid = 1'b0;
        checkEq("bp_second_pc", out_pc, 64'h204);
        step();
        checkEq("bp_third_pc", out_pc, 64'h208);
        checkEq("bp_third_valid", out_valid, 1);
        step();
        checkEq("bp_drained", out_valid, 0);

        // Flush with both ID and output occupied.
        out_ready = 1'b0;
        offer(64'h300, IAdd6x0);
        step();
        offer(64'h304, IAdd6x0);
        step();
        checkEq("fl_pre_out_valid", out_valid, 1);
        offer(64'h308, IAdd6x0);
        flush = 1'b1;
        #1;
        checkEq("fl_in_ready", in_ready, 0);
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        checkEq("fl_out_valid", out_valid, 0);
        step();
        checkEq("fl_nothing_captured", out_valid, 0);

        // Stall counter saturates at 7 (was 2).
        offer(64'h400, IAdd4x3);
        step();
        in_valid = 1'b0;
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd3;
        for (int i = 0; i < 4; i++) step();
        checkEq("sat_cnt_6", stall_cnt, 6);
        for (int i = 0; i < 4; i++) step();
        checkEq("sat_cnt_7", stall_cnt, 7);

        // Mid-operation reset discards everything.
        rst_n = 1'b0;
        step();
        checkEq("midrst_out_valid", out_valid, 0);
        checkEq("midrst_stall_cnt", stall_cnt, 0);
        checkEq("midrst_out_rs1", out_rs1_val, 0);
        rst_n = 1'b1;
        clearFwd();
        step();
        checkEq("midrst_no_leftover", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
